// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - JK excitation encodings and helper shared by the counter slice
//
// Purpose:
//   Holds the {j,k} pair encodings and the function that maps a present
//   bit value and a desired next bit value onto the JK excitation for one
//   stage.
// Contents:
//   JK_HOLD, JK_CLR, JK_SET, JK_TOG  {j,k} encodings
//   jk_excite(q, nxt)                returns {j,k} for one stage
package jk_pkg;

  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TOG  = 2'b11;

  // A 0->1 transition needs J, a 1->0 transition needs K, and an unchanged
  // bit needs neither. Toggle is therefore never produced.
  function automatic logic [1:0] jk_excite(input logic q, input logic nxt);
    return {~q & nxt, q & ~nxt};
  endfunction

endpackage

// File: rtl/jk_stage.sv
// rtl/jk_stage.sv - single JK flip-flop stage with complementary outputs
//
// Purpose:
//   One JK flip-flop. On each rising clk the {j,k} pair selects hold,
//   clear, set or toggle. An asynchronous active-low reset forces q to 0.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous reset, active low
//   j      in   J excitation
//   k      in   K excitation
//   q      out  stored bit
//   qbar   out  complement of q, including while reset is asserted
module jk_stage
  import jk_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  logic r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD: r_q <= r_q;
        JK_CLR:  r_q <= 1'b0;
        JK_SET:  r_q <= 1'b1;
        JK_TOG:  r_q <= ~r_q;
        default: r_q <= r_q;
      endcase
    end
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

// File: rtl/jk_mod_counter.sv
// rtl/jk_mod_counter.sv - modulo-MOD up/down counter built from JK stages
module jk_mod_counter
  import jk_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_n,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc,
  output logic             load_err
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ONE_C = WIDTH'(1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qn;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_din_oor;
  logic             r_load_err;

  assign w_at_max  = (w_q == MAX_C);
  assign w_at_zero = (w_q == '0);
  assign w_din_oor = ({1'b0, din} >= MOD_W);

  always_comb begin
    w_nxt = w_q;
    if (load) begin
      w_nxt = w_din_oor ? MAX_C : din;
    end else if (en) begin
      if (up) begin
        w_nxt = w_at_max ? '0 : (w_q + ONE_C);
      end else begin
        w_nxt = w_at_zero ? MAX_C : (w_q - ONE_C);
      end
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_stage
    assign {w_j[gi], w_k[gi]} = jk_excite(w_q[gi], w_nxt[gi]);

    jk_stage u_stage (
      .clk  (clk),
      .reset(reset),
      .j    (w_j[gi]),
      .k    (w_k[gi]),
      .q    (w_q[gi]),
      .qbar (w_qn[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_load_err <= 1'b0;
    end else if (load && w_din_oor) begin
      r_load_err <= 1'b1;
    end
  end

  assign count    = w_q;
  assign count_n  = w_qn;
  assign j_vec    = w_j;
  assign k_vec    = w_k;
  assign tc       = en & ~load & (up ? w_at_max : w_at_zero);
  assign load_err = r_load_err;

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb/tb_jk_mod_counter.sv - self-checking bench for jk_mod_counter
module tb_jk_mod_counter;

  localparam int WIDTH = 4;
  localparam int MOD   = 10;

  logic             clk;
  logic             reset;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] j_vec;
  logic [WIDTH-1:0] k_vec;
  logic             tc;
  logic             load_err;

  int n_checks;
  int n_fail;

  // reference state
  int m_count;
  int m_err;

  jk_mod_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .up      (up),
    .load    (load),
    .din     (din),
    .count   (count),
    .count_n (count_n),
    .j_vec   (j_vec),
    .k_vec   (k_vec),
    .tc      (tc),
    .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_next(input int c, input logic e, input logic u,
                                    input logic l, input int d);
    if (l) return (d < MOD) ? d : MOD - 1;
    if (e) return u ? (c + 1) % MOD : (c + MOD - 1) % MOD;
    return c;
  endfunction

  // Apply inputs, check the combinational outputs, clock once, check state.
  task automatic step(input logic i_en, input logic i_up, input logic i_load,
                      input logic [WIDTH-1:0] i_din);
    int nx;
    int exp_tc;
    en = i_en; up = i_up; load = i_load; din = i_din;
    #1;
    nx = model_next(m_count, i_en, i_up, i_load, int'(i_din));
    exp_tc = (i_en && !i_load && (i_up ? (m_count == MOD - 1) : (m_count == 0))) ? 1 : 0;
    check("tc", 32'(tc), 32'(exp_tc));
    check("j_vec", 32'(j_vec), 32'((~m_count & nx) & 15));
    check("k_vec", 32'(k_vec), 32'((m_count & ~nx) & 15));
    @(posedge clk);
    #1;
    m_count = nx;
    if (i_load && int'(i_din) >= MOD) m_err = 1;
    check("count", 32'(count), 32'(m_count));
    check("count_n", 32'(count_n), 32'((~m_count) & 15));
    check("load_err", 32'(load_err), 32'(m_err));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_count  = 0;
    m_err    = 0;

    // 1. reset held across edges with en=1
    reset = 1'b0; en = 1'b1; up = 1'b1; load = 1'b0; din = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_count_n", 32'(count_n), 32'hF);
    check("rst_load_err", 32'(load_err), 32'd0);
    check("rst_tc", 32'(tc), 32'd0);
    reset = 1'b1;

    // 2. up count with wrap, explicit look at the 9->0 excitation
    for (int i = 0; i < 12; i++) begin
      if (m_count == MOD - 1) begin
        en = 1'b1; up = 1'b1; load = 1'b0;
        #1;
        check("wrap_j", 32'(j_vec), 32'h0);
        check("wrap_k", 32'(k_vec), 32'h9);
      end
      step(1'b1, 1'b1, 1'b0, 4'(i));
    end
    check("up_end", 32'(count), 32'd2);

    // 3. down wrap
    step(1'b0, 1'b0, 1'b1, 4'd2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, '0);
    check("down_end", 32'(count), 32'd8);

    // 4. load priority and range
    step(1'b1, 1'b1, 1'b1, 4'd7);
    check("ld7", 32'(count), 32'd7);
    step(1'b1, 1'b0, 1'b1, 4'd12);
    check("ld12", 32'(count), 32'd9);
    check("ld12_err", 32'(load_err), 32'd1);
    step(1'b1, 1'b1, 1'b1, 4'd3);
    check("ld3_err", 32'(load_err), 32'd1);

    // 5. hold with random up/din
    for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'b0, 4'($urandom));
    check("hold_count", 32'(count), 32'd3);

    // 6. async reset mid-count
    step(1'b0, 1'b0, 1'b1, 4'd6);
    en = 1'b0; load = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    m_count = 0;
    m_err = 0;
    check("async_count", 32'(count), 32'd0);
    check("async_count_n", 32'(count_n), 32'hF);
    check("async_err", 32'(load_err), 32'd0);
    #1;
    reset = 1'b1;
    step(1'b1, 1'b1, 1'b0, '0);
    check("post_rst", 32'(count), 32'd1);

    // randomized run against the reference model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom),
           1'($urandom_range(0, 7) == 0), 4'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
